// File: rtl/rr_demux_ctrl.sv
// Round-robin 1-to-4 demux controller: one registered beat slot that is routed
// to a rotating channel, BURST beats per channel, skipping disabled channels.
module rr_demux_ctrl #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       ch_en,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel
);

    // state | meaning
    // EMPTY | holding register free, a beat may be accepted
    // HOLD  | holding register carries a beat for channel dest_q
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    logic [0:0]       state_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       dest_q;
    logic [1:0]       sel_q;
    logic [3:0]       cnt_q;
    logic             ch_any;
    logic             accept;
    logic             deliver;
    logic [1:0]       sel_next_en;

    // First enabled channel strictly after cur in rotation order; cur itself
    // is kept when no other channel is enabled.
    function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] en);
        logic [1:0] cand;
        next_en = cur;
        for (int i = 3; i >= 1; i--) begin
            cand = cur + 2'(i);
            if (en[cand]) next_en = cand;
        end
    endfunction

    assign ch_any      = |ch_en;
    assign deliver     = (state_q == HOLD) && out_ready[dest_q];
    assign in_ready    = ch_any && ((state_q == EMPTY) || out_ready[dest_q]);
    assign accept      = in_valid && in_ready;
    assign sel_next_en = next_en(sel_q, ch_en);

    assign out_data  = data_q;
    assign out_valid = (state_q == HOLD) ? (4'b0001 << dest_q) : 4'b0000;
    assign sel       = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= 2'b00;
        end else if (accept) begin
            state_q <= HOLD;
            data_q  <= in_data;
            dest_q  <= sel_q;
        end else if (deliver) begin
            state_q <= EMPTY;
        end
    end

    // A disabled current channel abandons its burst; the realign wins over
    // any acceptance counted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 2'b00;
            cnt_q <= 4'd0;
        end else if (ch_any) begin
            if (!ch_en[sel_q]) begin
                sel_q <= sel_next_en;
                cnt_q <= 4'd0;
            end else if (accept) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= 4'd0;
                    sel_q <= sel_next_en;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_demux_ctrl.sv
// Directed self-checking bench for rr_demux_ctrl with BURST=4, 2 and 1 instances.
module tb_rr_demux_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] out_ready;
    logic [3:0] ch_en4;
    logic [3:0] ch_en2;

    logic       ready4, ready2, ready1;
    logic [7:0] odata4, odata2, odata1;
    logic [3:0] ovalid4, ovalid2, ovalid1;
    logic [1:0] sel4, sel2, sel1;

    int checks = 0;
    int errors = 0;

    rr_demux_ctrl #(.WIDTH(8), .BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready4), .ch_en(ch_en4), .out_data(odata4),
        .out_valid(ovalid4), .out_ready(out_ready), .sel(sel4));

    rr_demux_ctrl #(.WIDTH(8), .BURST(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready2), .ch_en(ch_en2), .out_data(odata2),
        .out_valid(ovalid2), .out_ready(out_ready), .sel(sel2));

    rr_demux_ctrl #(.WIDTH(8), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready1), .ch_en(ch_en4), .out_data(odata1),
        .out_valid(ovalid1), .out_ready(out_ready), .sel(sel1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beats(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(base + k);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ch_en4 = 4'hF; out_ready = 4'hF;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got %b exp 0000", ovalid4); end
        checks++; if (odata4 !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", odata4); end
        checks++; if (sel4 !== 2'b00) begin errors++; $display("FAIL rst_sel got %0d exp 0", sel4); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", ready4); end
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL rst_no_accept got %b exp 0000", ovalid4); end
        ch_en4 = 4'h0;
        #1;
        checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL rst_ready_chen0 got %b exp 0", ready4); end
        in_valid = 1'b0; ch_en4 = 4'hF;
    endtask

    task automatic test_stream;
        logic [3:0] exp_v;
        @(negedge clk);
        rst_n = 1'b1; ch_en4 = 4'hF; out_ready = 4'hF; in_valid = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_v = 4'b0001 << ((i - 1) / 4);
                checks++; if (ovalid4 !== exp_v) begin errors++; $display("FAIL stream_valid beat %0d got %b exp %b", i-1, ovalid4, exp_v); end
                checks++; if (odata4 !== 8'(i - 1)) begin errors++; $display("FAIL stream_data beat %0d got %h exp %h", i-1, odata4, 8'(i-1)); end
                exp_v = 4'b0001 << ((i - 1) % 4);
                checks++; if (ovalid1 !== exp_v) begin errors++; $display("FAIL burst1_valid beat %0d got %b exp %b", i-1, ovalid1, exp_v); end
            end
            if (i < 16) begin
                checks++; if (sel4 !== 2'(i / 4)) begin errors++; $display("FAIL stream_sel beat %0d got %0d exp %0d", i, sel4, i/4); end
                in_valid = 1'b1; in_data = 8'(i);
                #1;
                checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL stream_ready beat %0d got %b exp 1", i, ready4); end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL stream_drain got %b exp 0000", ovalid4); end
        checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL stream_wrap_sel got %0d exp 0", sel4); end
        checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL burst1_wrap_sel got %0d exp 0", sel1); end
    endtask

    task automatic test_burst2;
        logic [1:0] ch;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ch_en2 = 4'b1010; out_ready = 4'hF;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (j > 0) begin
                ch = (((j - 1) / 2) % 2 == 1) ? 2'd3 : 2'd1;
                checks++; if (ovalid2 !== (4'b0001 << ch)) begin errors++; $display("FAIL burst2_valid beat %0d got %b exp ch %0d", j-1, ovalid2, ch); end
                checks++; if (odata2 !== 8'(8'h40 + j - 1)) begin errors++; $display("FAIL burst2_data beat %0d got %h exp %h", j-1, odata2, 8'(8'h40 + j - 1)); end
            end
            if (j < 8) begin
                ch = ((j / 2) % 2 == 1) ? 2'd3 : 2'd1;
                checks++; if (sel2 !== ch) begin errors++; $display("FAIL burst2_sel beat %0d got %0d exp %0d", j, sel2, ch); end
                in_valid = 1'b1; in_data = 8'(8'h40 + j);
            end else begin
                in_valid = 1'b0;
                checks++; if (sel2 !== 2'd1) begin errors++; $display("FAIL burst2_end_sel got %0d exp 1", sel2); end
            end
        end
    endtask

    task automatic test_hold;
        do_reset();
        send_beats(8, 0);
        @(negedge clk);
        out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'hA5;
        #1;
        checks++; if (sel4 !== 2'd2) begin errors++; $display("FAIL hold_sel got %0d exp 2", sel4); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_data = 8'h5A;
            #1;
            checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL hold_ready cycle %0d got %b exp 0", c, ready4); end
            checks++; if (ovalid4 !== 4'b0100) begin errors++; $display("FAIL hold_valid cycle %0d got %b exp 0100", c, ovalid4); end
            checks++; if (odata4 !== 8'hA5) begin errors++; $display("FAIL hold_data cycle %0d got %h exp a5", c, odata4); end
        end
        @(negedge clk);
        checks++; if (odata4 !== 8'hA5) begin errors++; $display("FAIL hold_data_pre got %h exp a5", odata4); end
        out_ready = 4'hF;
        #1;
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", ready4); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (odata4 !== 8'h5A) begin errors++; $display("FAIL hold_next_data got %h exp 5a", odata4); end
        checks++; if (ovalid4 !== 4'b0100) begin errors++; $display("FAIL hold_next_valid got %b exp 0100", ovalid4); end
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL hold_drain got %b exp 0000", ovalid4); end
    endtask

    task automatic test_realign;
        do_reset();
        send_beats(6, 0);
        @(negedge clk);
        in_valid = 1'b0; ch_en4 = 4'b1101; out_ready = 4'b1101;
        #1;
        checks++; if (sel4 !== 2'd1) begin errors++; $display("FAIL realign_sel_pre got %0d exp 1", sel4); end
        checks++; if (ovalid4 !== 4'b0010) begin errors++; $display("FAIL realign_valid_pre got %b exp 0010", ovalid4); end
        @(negedge clk);
        checks++; if (sel4 !== 2'd2) begin errors++; $display("FAIL realign_sel got %0d exp 2", sel4); end
        checks++; if (ovalid4 !== 4'b0010) begin errors++; $display("FAIL realign_dest_kept got %b exp 0010", ovalid4); end
        checks++; if (odata4 !== 8'd5) begin errors++; $display("FAIL realign_data got %h exp 05", odata4); end
        out_ready = 4'hF;
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL realign_delivered got %b exp 0000", ovalid4); end
        for (int j = 0; j <= 4; j++) begin
            if (j > 0) begin
                checks++; if (ovalid4 !== 4'b0100) begin errors++; $display("FAIL realign_burst_valid beat %0d got %b exp 0100", j-1, ovalid4); end
                checks++; if (odata4 !== 8'(20 + j - 1)) begin errors++; $display("FAIL realign_burst_data beat %0d got %h exp %h", j-1, odata4, 8'(20 + j - 1)); end
            end
            if (j < 4) begin
                in_valid = 1'b1; in_data = 8'(20 + j);
                @(negedge clk);
            end else begin
                in_valid = 1'b0;
                checks++; if (sel4 !== 2'd3) begin errors++; $display("FAIL realign_rotate_sel got %0d exp 3", sel4); end
            end
        end
    endtask

    task automatic test_disable;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ch_en4 = 4'h0; in_valid = 1'b1; in_data = 8'd30;
            #1;
            checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL disable_ready cycle %0d got %b exp 0", c, ready4); end
            checks++; if (sel4 !== 2'd3) begin errors++; $display("FAIL disable_sel cycle %0d got %0d exp 3", c, sel4); end
        end
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL disable_no_accept got %b exp 0000", ovalid4); end
        ch_en4 = 4'hF;
        #1;
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL enable_ready got %b exp 1", ready4); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (ovalid4 !== 4'b1000) begin errors++; $display("FAIL enable_valid got %b exp 1000", ovalid4); end
        checks++; if (odata4 !== 8'd30) begin errors++; $display("FAIL enable_data got %h exp 1e", odata4); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'd77;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (ovalid4 !== 4'b1000) begin errors++; $display("FAIL arst_hold got %b exp 1000", ovalid4); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ovalid4 !== 4'b0000) begin errors++; $display("FAIL arst_valid got %b exp 0000", ovalid4); end
        checks++; if (odata4 !== 8'h00) begin errors++; $display("FAIL arst_data got %h exp 00", odata4); end
        checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL arst_sel got %0d exp 0", sel4); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 4'hF; ch_en4 = 4'hF;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd88;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (ovalid4 !== 4'b0001) begin errors++; $display("FAIL arst_first_valid got %b exp 0001", ovalid4); end
        checks++; if (odata4 !== 8'd88) begin errors++; $display("FAIL arst_first_data got %h exp 58", odata4); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 4'hF; ch_en4 = 4'hF; ch_en2 = 4'b1010;
        test_reset();
        test_stream();
        test_burst2();
        test_hold();
        test_realign();
        test_disable();
        test_async_reset();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_demux_ctrl.md
RR_DEMUX_CTRL -- requirements
Module: rr_demux_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data beat width in bits.
REQ-002 Parameter BURST, default 4, beats sent to one channel before rotating; legal range 1..16.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1, upstream beat present.
REQ-006 Port in_data, input, WIDTH, upstream beat payload.
REQ-007 Port in_ready, output, 1, block accepts a beat this cycle.
REQ-008 Port ch_en, input, 4, per-channel enable mask; bit k enables channel k.
REQ-009 Port out_data, output, WIDTH, shared registered payload to all four channels.
REQ-010 Port out_valid, output, 4, one-hot (or zero) channel strobe; bit k = beat for channel k.
REQ-011 Port out_ready, input, 4, per-channel downstream ready.
REQ-012 Port sel, output, 2, channel code {s1,s0} that the next accepted beat will be routed to.

Function
REQ-013 A beat is accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-014 A beat is delivered when out_valid[k] and out_ready[k] are both 1 on a rising clk edge.
REQ-015 The block has one output holding register (data, 2-bit dest, full flag) with states EMPTY (full=0) and HOLD (full=1).
REQ-016 out_valid[k] = full AND (dest == k); out_valid is never multi-hot.
REQ-017 in_ready = (ch_en != 0) AND (NOT full OR out_ready[dest]), combinational; deliver and accept in one cycle is allowed.
REQ-018 On acceptance: data <= in_data, dest <= sel, full <= 1; latency is in-to-out one cycle.
REQ-019 On delivery without acceptance: full <= 0 (HOLD -> EMPTY); with acceptance, full stays 1 and is loaded with the new beat.
REQ-020 A beat counter (0..BURST-1) increments on every acceptance; when it equals BURST-1 on acceptance, it clears to 0 and sel rotates.
REQ-021 Rotation: sel advances to the next enabled channel in order 0->1->2->3->0, skipping channels with ch_en bit 0; if only the current channel is enabled, sel is unchanged.
REQ-022 If ch_en[sel] is 0 while ch_en != 0, sel moves in the next cycle to the next enabled channel after sel and the beat counter clears to 0; an interrupted burst is not resumed.
REQ-023 If ch_en == 0: in_ready = 0, sel and beat counter hold; a beat already in HOLD is still delivered to its dest.
REQ-024 Changes to ch_en never alter dest of a beat already in HOLD.
REQ-025 out_data holds its value when not loaded; no data is dropped or duplicated under any out_ready pattern.
REQ-026 BURST = 1 rotates sel on every acceptance.

Reset
REQ-027 rst_n low asynchronously forces full = 0, out_valid = 4'b0000, out_data = 0, dest = 0, sel = 2'b00, beat counter = 0.
REQ-028 in_ready during reset follows REQ-017 with full = 0 (i.e. equals ch_en != 0); acceptances are ignored while rst_n is low.
REQ-029 Reset asserted mid-burst or while in HOLD discards the held beat; after release, the first accepted beat goes to channel 0 (or the first enabled channel per REQ-022).

Verification
REQ-030 BURST=4, ch_en=1111, out_ready=1111, in_valid=1 with data 0..15 -> data 0-3 on out_valid=0001, 4-7 on 0010, 8-11 on 0100, 12-15 on 1000, one beat per cycle, first out_valid one cycle after first acceptance.
REQ-031 ch_en=1010, BURST=2, 8 beats -> channels 1,1,3,3,1,1,3,3; sel never 0 or 2 after the first cycle.
REQ-032 HOLD with dest=2, out_ready[2]=0 for 5 cycles, in_valid=1 -> in_ready=0, out_data and out_valid=0100 stable for 5 cycles, no acceptance; out_ready[2]=1 -> delivery and new acceptance in the same cycle.
REQ-033 Mid-burst (counter=2, sel=1) clear ch_en[1] -> next cycle sel=2, counter=0; the beat already in HOLD still delivered on channel 1.
REQ-034 ch_en=0000 -> in_ready=0 indefinitely, sel stable; restore ch_en=1111 -> traffic resumes at the held sel.
REQ-035 Assert rst_n=0 asynchronously (between edges) while in HOLD -> out_valid=0000 immediately; after release, first beat goes to channel 0.
